time_set_ctrl: RTL

User-input front end for the alarm clock. It debounces the raw mode/inc/dec buttons and runs an edit FSM. The FSM freezes the time-keeping counter chain, lets the user adjust hours and minutes, then issues a one-cycle load of the edited time back into the hour/minute/second counters. The display reads time out of the counter chain; this block writes time into it.

---
 rtl/time_set_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Alarm-clock time-set front end: debounces mode/inc/dec, runs the edit FSM and loads the edited time.
// Optional build macro TIME_SET_AUTOREPEAT_EN adds hold-to-repeat stepping on inc/dec.

module time_set_db #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_BITS         = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic lvl_o
);
  localparam logic [DB_BITS-1:0] DB_MAX = DB_BITS'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               lvl_q, lvl_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;

  // Any return to the accepted level restarts the count, so short glitches never land.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_MAX) begin
      lvl_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl_o = lvl_q;
endmodule

module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_BITS         = 20,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int BLINK_BITS      = 25
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       run_en,
  output logic       load_en,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic [1:0] set_state,
  output logic       blink
);
  localparam int NUM_BTN = 3;
  localparam int B_MODE  = 0;
  localparam int B_INC   = 1;
  localparam int B_DEC   = 2;
  localparam logic [BLINK_BITS-1:0] BL_MAX = BLINK_BITS'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_e;

  logic [NUM_BTN-1:0] btn_raw, lvl, lvl_prev_q, press;

  assign btn_raw = {btn_dec, btn_inc, btn_mode};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    time_set_db #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_BITS        (DB_BITS)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_btn),
      .btn_i(btn_raw[g]),
      .lvl_o(lvl[g])
    );
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) lvl_prev_q <= '0;
    else          lvl_prev_q <= lvl;
  end

  assign press = lvl & ~lvl_prev_q;

  // Mode outranks steps; coincident inc+dec cancel each other.
  logic mode_ev, inc_ev, dec_ev;
  assign mode_ev = press[B_MODE];
  assign inc_ev  = press[B_INC] & ~press[B_DEC] & ~press[B_MODE];
  assign dec_ev  = press[B_DEC] & ~press[B_INC] & ~press[B_MODE];

  state_e     state_q, state_d;
  logic [4:0] eh_q, eh_d;
  logic [5:0] em_q, em_d;
  logic       run_en_q, run_en_d;
  logic       load_en_q, load_en_d;
  logic       in_set;
  logic       rpt_inc, rpt_dec;
  logic       step_inc, step_dec;

  assign in_set = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int REPEAT_DELAY = 50000000;
  localparam int REPEAT_RATE  = 10000000;
  localparam logic [25:0] RPT_DLY_MAX  = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0] RPT_RATE_MAX = 26'(REPEAT_RATE - 1);

  logic [25:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_arm_q, rpt_arm_d;
  logic        rpt_step;

  // arm flag selects the long initial delay vs the steady repeat rate
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_arm_d = rpt_arm_q;
    rpt_step  = 1'b0;
    if (!(in_set && !mode_ev && (lvl[B_INC] ^ lvl[B_DEC]))) begin
      rpt_cnt_d = '0;
      rpt_arm_d = 1'b0;
    end else if (rpt_cnt_q == (rpt_arm_q ? RPT_RATE_MAX : RPT_DLY_MAX)) begin
      rpt_step  = 1'b1;
      rpt_cnt_d = '0;
      rpt_arm_d = 1'b1;
    end else begin
      rpt_cnt_d = rpt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      rpt_cnt_q <= '0;
      rpt_arm_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
    end
  end

  assign rpt_inc = rpt_step & lvl[B_INC];
  assign rpt_dec = rpt_step & lvl[B_DEC];
`else
  assign rpt_inc = 1'b0;
  assign rpt_dec = 1'b0;
`endif

  assign step_inc = inc_ev | rpt_inc;
  assign step_dec = dec_ev | rpt_dec;

  always_comb begin
    state_d = state_q;
    eh_d    = eh_q;
    em_d    = em_q;
    case (state_q)
      ST_RUN: begin
        if (mode_ev) begin
          state_d = ST_SET_HOUR;
          eh_d    = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
          em_d    = (cur_min > 6'd59) ? 6'd0 : cur_min;
        end
      end
      ST_SET_HOUR: begin
        if (mode_ev)       state_d = ST_SET_MIN;
        else if (step_inc) eh_d = (eh_q >= 5'd23) ? 5'd0 : eh_q + 5'd1;
        else if (step_dec) eh_d = (eh_q == 5'd0) ? 5'd23 : eh_q - 5'd1;
      end
      ST_SET_MIN: begin
        if (mode_ev)       state_d = ST_COMMIT;
        else if (step_inc) em_d = (em_q >= 6'd59) ? 6'd0 : em_q + 6'd1;
        else if (step_dec) em_d = (em_q == 6'd0) ? 6'd59 : em_q - 6'd1;
      end
      default: state_d = ST_RUN;
    endcase
    run_en_d  = (state_d == ST_RUN);
    load_en_d = (state_d == ST_COMMIT);
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q   <= ST_RUN;
      eh_q      <= '0;
      em_q      <= '0;
      run_en_q  <= 1'b1;
      load_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      eh_q      <= eh_d;
      em_q      <= em_d;
      run_en_q  <= run_en_d;
      load_en_q <= load_en_d;
    end
  end

  logic [BLINK_BITS-1:0] blk_cnt_q, blk_cnt_d;
  logic                  blink_q, blink_d;

  // Every state change restarts the blink phase so a freshly selected field starts visible.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blink_d   = blink_q;
    if (!in_set || (state_d != state_q)) begin
      blk_cnt_d = '0;
      blink_d   = 1'b0;
    end else if (blk_cnt_q == BL_MAX) begin
      blk_cnt_d = '0;
      blink_d   = ~blink_q;
    end else begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
    end
  end

  assign run_en    = run_en_q;
  assign load_en   = load_en_q;
  assign edit_hour = eh_q;
  assign edit_min  = em_q;
  assign set_state = state_q;
  assign blink     = blink_q;
endmodule
